pkt_axi_rd_stream: RTL and testbench
====================================

Name: pkt_axi_rd_stream

Overview:
- AXI4 read initiator that drains one packet from a byte-pointer packet buffer's AXI slave read port and re-emits it as an 8-bit AXI-Stream.
- Counterpart to the InFIFO read responder: used on the host/loopback side to pull received UDP payloads out over AXI and stream them byte-by-byte.
- Controlled by a start/length command; reports done and a sticky response error.

Parameters:
- BASE_ADDR, 32'h0, araddr driven on every burst (FIXED burst; slave ignores address).
- AXI_ID, 0, arid driven on every burst; rid is not checked.
- MAX_BURST, 16, maximum beats per AR burst (1..256); arlen = beats-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- axi_mosi  out  s_axi_mosi_t  AXI master request channels; only AR and rready are used, all AW/W/B fields are tied 0.
- axi_miso  in  s_axi_miso_t  AXI slave responses (arready, R channel).
- axis_mosi  out  s_axis_mosi_t  byte stream out (tvalid, tdata[7:0], tlast).
- axis_miso  in  s_axis_miso_t  tready.
- cmd_start_i  in  1  level request; a packet is sampled only in IDLE.
- cmd_len_i  in  udp_length_t  packet length in bytes, sampled on leaving IDLE.
- done_o  out  1  one-cycle pulse on the final byte handshake, or on a zero-length command.
- busy_o  out  1  high in any state except IDLE.
- err_o  out  1  sticky: some rresp != OKAY since last start; cleared on next start.

Behaviour:
- Reset (rst==0, any cycle, including mid-burst): FSM to IDLE, all counters 0, hold register empty, every output 0. Outstanding AXI beats are abandoned; the slave shares the same reset.
- Registers:
  - len_ff: latched byte length.
  - words_left_ff = ceil(len/4), width of udp_length_t.
  - beats_left_ff: beats remaining in the current burst.
  - byte_cnt_ff: bytes emitted.
  - hold_ff[31:0], hold_vld_ff, lane_ff[1:0].
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - cmd_start_i=1 and cmd_len_i=0: go to DONE, pulse done_o, no AXI traffic.
  - cmd_start_i=1 and cmd_len_i>0: latch the command, clear err_o, go to ADDR.
- ADDR:
  - arvalid=1; arlen = min(MAX_BURST, words_left)-1; arsize=2; arburst=FIXED; arid=AXI_ID; araddr=BASE_ADDR.
  - arvalid holds stable until arready.
  - On handshake: beats_left = arlen+1, words_left -= arlen+1, go to DATA.
  - Only one outstanding burst at any time.
- DATA:
  - rready = ~hold_vld_ff.
  - On R handshake: hold_ff = rdata, hold_vld=1, lane=0, beats_left -= 1; rresp != 0 sets err_o.
  - rlast is not used for control; beat counting is authoritative.
  - Serializer: tvalid = hold_vld_ff; tdata = hold_ff byte[lane_ff], little-endian (lane 0 = bits[7:0] first).
  - tlast = (byte_cnt_ff == len_ff-1).
  - On tvalid&&tready: byte_cnt++, lane++.
  - hold_vld clears when lane==3 or the byte is tlast.
  - Trailing bytes of the final partial word are discarded.
  - Throughput: 4 bytes per 5 cycles at full tready. The bubble cycle is accepted; no combinational path from tready to rready.
  - After the last beat of a burst is consumed: words_left>0 goes to ADDR, else stays until the tlast handshake.
  - tlast handshake: done_o=1 for that cycle, go to DONE.
- DONE: stay while cmd_start_i=1, then return to IDLE (level handshake, same as the buffer side).
- cmd_start_i/cmd_len_i changes outside IDLE are ignored.
- Width rules: length arithmetic uses udp_length_t; words = (len+3)>>2 with no overflow at max length.

Decomposition:
- Add pkt_rd_st_t (IDLE/ADDR/DATA/DONE) to utils_pkg next to fsm_pkt_t.
- Reuse s_axi_*_t, s_axis_*_t, udp_length_t, axi_alen_t.
- Add constant AXI_BURST_FIXED to utils_pkg.
- One natural sub-module: pkt_word2byte (32-bit hold register + lane counter + tlast generation), instantiated once.

Test Plan:
- len=1, slave returns rdata=32'hDDCCBBAA:
  - one AR with arlen=0.
  - single byte 8'hAA with tlast=1.
  - done_o pulses once; remaining bytes dropped.
- len=7:
  - arlen=1 (2 beats).
  - bytes 00..06 of the incrementing pattern, tlast only on the 7th byte.
  - busy_o low two cycles after DONE with cmd_start_i dropped.
- len=70, MAX_BURST=16:
  - two ARs, arlen=15 then arlen=1, never overlapping.
  - 70 bytes in order; last word yields 2 bytes; tlast on byte 70.
- len=20 with random tready (30% low) and arready delayed 3 cycles:
  - byte order intact; tdata/tvalid stable while tready=0.
  - araddr/arlen stable while arvalid && !arready.
- len=8, second beat rresp=2'b10:
  - all 8 bytes still streamed; err_o=1 after that beat.
  - err_o stays 1 through DONE; clears on the next start.
- Edge cases:
  - len=0: done_o pulse with no arvalid.
  - rst=0 asserted mid-DATA on len=40: the next cycle shows all outputs 0 and FSM in IDLE; a subsequent len=4 command completes normally.

Source files
------------

// File: rtl/pkt_axi_rd_stream_pkg.sv
// rtl/pkt_axi_rd_stream_pkg.sv - shared types, constants and helpers for the AXI read-to-stream block
package pkt_axi_rd_stream_pkg;

    typedef logic [15:0] udp_length_t;
    typedef logic [7:0]  axi_alen_t;
    typedef logic [3:0]  axi_id_t;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B     = 3'd2;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        PKT_RD_IDLE = 2'd0,
        PKT_RD_ADDR = 2'd1,
        PKT_RD_DATA = 2'd2,
        PKT_RD_DONE = 2'd3
    } pkt_rd_st_t;

    typedef struct packed {
        axi_id_t     awid;
        logic [31:0] awaddr;
        axi_alen_t   awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
        axi_id_t     arid;
        logic [31:0] araddr;
        axi_alen_t   arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        axi_id_t     bid;
        logic [1:0]  bresp;
        logic        bvalid;
        logic        arready;
        axi_id_t     rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
    } s_axi_miso_t;

    typedef struct packed {
        logic       tvalid;
        logic [7:0] tdata;
        logic       tlast;
    } s_axis_mosi_t;

    typedef struct packed {
        logic tready;
    } s_axis_miso_t;

    // ceil(len/4) computed one bit wider so the maximum length cannot wrap
    function automatic udp_length_t len_to_words(input udp_length_t len);
        logic [16:0] w_sum;
        w_sum = {1'b0, len} + 17'd3;
        return udp_length_t'(w_sum[16:2]);
    endfunction

endpackage

// File: rtl/pkt_axi_rd_stream_if.sv
// rtl/pkt_axi_rd_stream_if.sv - AXI read and AXI-Stream bundle between the block and its peers
interface pkt_axi_rd_stream_if;
    import pkt_axi_rd_stream_pkg::*;

    s_axi_mosi_t  axi_mosi;
    s_axi_miso_t  axi_miso;
    s_axis_mosi_t axis_mosi;
    s_axis_miso_t axis_miso;

    modport master (
        output axi_mosi,
        output axis_mosi,
        input  axi_miso,
        input  axis_miso
    );

    modport slave (
        input  axi_mosi,
        input  axis_mosi,
        output axi_miso,
        output axis_miso
    );
endinterface

// File: rtl/pkt_axi_rd_stream_word2byte.sv
// rtl/pkt_axi_rd_stream_word2byte.sv - 32-bit hold register serialised little-endian into bytes
module pkt_word2byte
    import pkt_axi_rd_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic [31:0] i_data,
    input  udp_length_t i_len,
    input  logic        i_tready,
    output logic        o_tvalid,
    output logic [7:0]  o_tdata,
    output logic        o_tlast,
    output logic        o_hold_vld
);
    logic [31:0] r_hold;
    logic        r_hold_vld;
    logic [1:0]  r_lane;
    udp_length_t r_byte_cnt;
    logic        w_byte_hs;

    assign o_tvalid   = r_hold_vld;
    assign o_hold_vld = r_hold_vld;
    assign o_tdata    = r_hold_vld ? r_hold[{r_lane, 3'b000} +: 8] : 8'h00;
    assign o_tlast    = r_hold_vld && (r_byte_cnt == i_len - 16'd1);
    assign w_byte_hs  = r_hold_vld && i_tready;

    // Load a word, then step through lanes; the tlast byte ends the word early
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_lane     <= '0;
            r_byte_cnt <= '0;
        end else begin
            if (i_clear) begin
                r_byte_cnt <= '0;
            end else if (w_byte_hs) begin
                r_byte_cnt <= r_byte_cnt + 16'd1;
            end
            if (i_load) begin
                r_hold     <= i_data;
                r_hold_vld <= 1'b1;
                r_lane     <= '0;
            end else if (w_byte_hs) begin
                r_lane <= r_lane + 2'd1;
                if (r_lane == 2'd3 || o_tlast) begin
                    r_hold_vld <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/pkt_axi_rd_stream.sv
// rtl/pkt_axi_rd_stream.sv - AXI4 read initiator draining one packet into an 8-bit stream
module pkt_axi_rd_stream
    import pkt_axi_rd_stream_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter axi_id_t     AXI_ID    = 4'h0,
    parameter int          MAX_BURST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    pkt_axi_rd_stream_if.master        bus,
    input  logic                       cmd_start_i,
    input  udp_length_t                cmd_len_i,
    output logic                       done_o,
    output logic                       busy_o,
    output logic                       err_o
);
    localparam udp_length_t MAX_BEATS = udp_length_t'(MAX_BURST);

    pkt_rd_st_t  r_state;
    pkt_rd_st_t  w_state_nxt;
    udp_length_t r_len;
    udp_length_t r_words_left;
    logic [8:0]  r_beats_left;
    logic        r_err;

    udp_length_t w_burst_beats;
    axi_alen_t   w_arlen;
    logic [8:0]  w_beats_full;
    logic        w_arvalid;
    logic        w_ar_hs;
    logic        w_rready;
    logic        w_r_hs;
    logic        w_accept;
    logic        w_tvalid;
    logic [7:0]  w_tdata;
    logic        w_tlast;
    logic        w_hold_vld;
    logic        w_last_hs;
    logic        w_unused;

    assign w_burst_beats = (r_words_left > MAX_BEATS) ? MAX_BEATS : r_words_left;
    assign w_arlen       = axi_alen_t'(w_burst_beats - 16'd1);
    assign w_beats_full  = {1'b0, w_arlen} + 9'd1;
    assign w_arvalid     = (r_state == PKT_RD_ADDR);
    assign w_ar_hs       = w_arvalid && bus.axi_miso.arready;
    // rready only looks at registered state, so tready never reaches it combinationally
    assign w_rready      = (r_state == PKT_RD_DATA) && !w_hold_vld && (r_beats_left != 9'd0);
    assign w_r_hs        = w_rready && bus.axi_miso.rvalid;
    assign w_accept      = (r_state == PKT_RD_IDLE) && cmd_start_i;
    assign w_last_hs     = (r_state == PKT_RD_DATA) && w_tvalid && w_tlast && bus.axis_miso.tready;

    assign busy_o = (r_state != PKT_RD_IDLE);
    assign err_o  = r_err;

    assign w_unused = ^{bus.axi_miso.awready, bus.axi_miso.wready, bus.axi_miso.bid,
                        bus.axi_miso.bresp, bus.axi_miso.bvalid, bus.axi_miso.rid,
                        bus.axi_miso.rlast};

    pkt_word2byte u_word2byte (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_accept),
        .i_load     (w_r_hs),
        .i_data     (bus.axi_miso.rdata),
        .i_len      (r_len),
        .i_tready   (bus.axis_miso.tready),
        .o_tvalid   (w_tvalid),
        .o_tdata    (w_tdata),
        .o_tlast    (w_tlast),
        .o_hold_vld (w_hold_vld)
    );

    // AR fields are zero unless a request is being presented
    always_comb begin
        bus.axi_mosi         = '0;
        bus.axi_mosi.arvalid = w_arvalid;
        bus.axi_mosi.rready  = w_rready;
        if (w_arvalid) begin
            bus.axi_mosi.arid    = AXI_ID;
            bus.axi_mosi.araddr  = BASE_ADDR;
            bus.axi_mosi.arlen   = w_arlen;
            bus.axi_mosi.arsize  = AXI_SIZE_4B;
            bus.axi_mosi.arburst = AXI_BURST_FIXED;
        end
    end

    // Stream output straight from the serializer
    always_comb begin
        bus.axis_mosi        = '0;
        bus.axis_mosi.tvalid = w_tvalid;
        bus.axis_mosi.tdata  = w_tdata;
        bus.axis_mosi.tlast  = w_tlast;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= PKT_RD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and done pulse
    always_comb begin
        w_state_nxt = r_state;
        done_o      = 1'b0;
        case (r_state)
            PKT_RD_IDLE: begin
                if (cmd_start_i) begin
                    if (cmd_len_i == '0) begin
                        done_o      = 1'b1;
                        w_state_nxt = PKT_RD_DONE;
                    end else begin
                        w_state_nxt = PKT_RD_ADDR;
                    end
                end
            end
            PKT_RD_ADDR: begin
                if (w_ar_hs) begin
                    w_state_nxt = PKT_RD_DATA;
                end
            end
            PKT_RD_DATA: begin
                if (w_last_hs) begin
                    done_o      = 1'b1;
                    w_state_nxt = PKT_RD_DONE;
                end else if (r_beats_left == 9'd0 && r_words_left != '0) begin
                    w_state_nxt = PKT_RD_ADDR;
                end
            end
            PKT_RD_DONE: begin
                if (!cmd_start_i) begin
                    w_state_nxt = PKT_RD_IDLE;
                end
            end
            default: w_state_nxt = PKT_RD_IDLE;
        endcase
    end

    // Command latch, word/beat accounting and sticky response error
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len        <= '0;
            r_words_left <= '0;
            r_beats_left <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err <= 1'b0;
                if (cmd_len_i != '0) begin
                    r_len        <= cmd_len_i;
                    r_words_left <= len_to_words(cmd_len_i);
                end
            end
            if (w_ar_hs) begin
                r_beats_left <= w_beats_full;
                r_words_left <= r_words_left - w_burst_beats;
            end else if (w_r_hs) begin
                r_beats_left <= r_beats_left - 9'd1;
            end
            if (w_r_hs && bus.axi_miso.rresp != AXI_RESP_OKAY) begin
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pkt_axi_rd_stream.sv
// tb/tb_pkt_axi_rd_stream.sv - directed self-checking bench with a behavioural AXI read slave
`timescale 1ns/1ps
module tb_pkt_axi_rd_stream;
    import pkt_axi_rd_stream_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_start_i = 1'b0;
    udp_length_t cmd_len_i = '0;
    logic        done_o;
    logic        busy_o;
    logic        err_o;

    pkt_axi_rd_stream_if bus ();

    pkt_axi_rd_stream #(
        .BASE_ADDR (32'h0),
        .AXI_ID    (4'h0),
        .MAX_BURST (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .cmd_start_i (cmd_start_i),
        .cmd_len_i   (cmd_len_i),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int pend_beats    = 0;
    int word_idx      = 0;
    int beat_idx      = 0;
    int ar_wait_cnt   = 0;
    int ar_delay      = 0;
    int tready_low    = 0;
    int err_beat      = -1;
    bit use_override  = 1'b0;
    int ar_hs_cnt     = 0;
    int arvalid_seen  = 0;
    int overlap_cnt   = 0;
    int done_cnt      = 0;
    int ar_stab_err   = 0;
    int axis_stab_err = 0;
    bit prev_ar_wait  = 1'b0;
    bit prev_t_wait   = 1'b0;
    logic [31:0] prev_araddr = '0;
    axi_alen_t   prev_arlen  = '0;
    logic [7:0]  prev_tdata  = '0;
    logic        prev_tlast  = 1'b0;
    axi_alen_t   arlen_q[$];
    logic [7:0]  byte_q[$];
    logic        last_q[$];

    // Slave and stream sink: drive at negedge, then account for the handshakes of the coming posedge
    always @(negedge clk) begin
        logic [7:0] base;
        base = 8'(word_idx * 4);
        bus.axi_miso.arready = bus.axi_mosi.arvalid && (ar_wait_cnt >= ar_delay);
        bus.axi_miso.rvalid  = (pend_beats > 0);
        bus.axi_miso.rdata   = use_override ? 32'hDDCCBBAA
                                            : {base + 8'd3, base + 8'd2, base + 8'd1, base};
        bus.axi_miso.rresp   = (beat_idx == err_beat) ? 2'b10 : 2'b00;
        bus.axi_miso.rlast   = (pend_beats == 1);
        bus.axis_miso.tready = (int'($urandom_range(0, 99)) >= tready_low);
        #1;
        if (!rst) begin
            pend_beats   = 0;
            ar_wait_cnt  = 0;
            prev_ar_wait = 1'b0;
            prev_t_wait  = 1'b0;
        end else begin
            if (bus.axi_mosi.arvalid) arvalid_seen++;
            if (prev_ar_wait && (!bus.axi_mosi.arvalid || bus.axi_mosi.araddr !== prev_araddr ||
                                 bus.axi_mosi.arlen !== prev_arlen)) ar_stab_err++;
            if (bus.axi_mosi.arvalid && bus.axi_miso.arready) begin
                if (pend_beats != 0) overlap_cnt++;
                arlen_q.push_back(bus.axi_mosi.arlen);
                pend_beats  += int'(bus.axi_mosi.arlen) + 1;
                ar_hs_cnt++;
                ar_wait_cnt  = 0;
                prev_ar_wait = 1'b0;
            end else if (bus.axi_mosi.arvalid) begin
                ar_wait_cnt++;
                prev_ar_wait = 1'b1;
                prev_araddr  = bus.axi_mosi.araddr;
                prev_arlen   = bus.axi_mosi.arlen;
            end else begin
                prev_ar_wait = 1'b0;
            end
            if (bus.axi_miso.rvalid && bus.axi_mosi.rready) begin
                pend_beats--;
                word_idx++;
                beat_idx++;
            end
            if (prev_t_wait && (!bus.axis_mosi.tvalid || bus.axis_mosi.tdata !== prev_tdata ||
                                bus.axis_mosi.tlast !== prev_tlast)) axis_stab_err++;
            if (bus.axis_mosi.tvalid && bus.axis_miso.tready) begin
                byte_q.push_back(bus.axis_mosi.tdata);
                last_q.push_back(bus.axis_mosi.tlast);
                prev_t_wait = 1'b0;
            end else if (bus.axis_mosi.tvalid) begin
                prev_t_wait = 1'b1;
                prev_tdata  = bus.axis_mosi.tdata;
                prev_tlast  = bus.axis_mosi.tlast;
            end else begin
                prev_t_wait = 1'b0;
            end
            if (done_o) done_cnt++;
        end
    end

    task automatic clear_monitor();
        arlen_q.delete();
        byte_q.delete();
        last_q.delete();
        word_idx      = 0;
        beat_idx      = 0;
        ar_hs_cnt     = 0;
        arvalid_seen  = 0;
        overlap_cnt   = 0;
        done_cnt      = 0;
        ar_stab_err   = 0;
        axis_stab_err = 0;
    endtask

    // Counts bytes that differ from the incrementing pattern or carry a misplaced tlast
    function automatic int pattern_errs(input int len);
        int bad = 0;
        for (int i = 0; i < byte_q.size(); i++) begin
            if (byte_q[i] !== 8'(i)) bad++;
            if (last_q[i] !== (i == len - 1)) bad++;
        end
        return bad;
    endfunction

    // Raise start with a length, wait (bounded) for done, then drop start on the next negedge
    task automatic run_cmd(input udp_length_t len, output bit ok);
        int n = 0;
        @(negedge clk);
        cmd_len_i   = len;
        cmd_start_i = 1'b1;
        #2;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        ok = (done_cnt != 0);
        @(negedge clk);
        cmd_start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        total_cnt++; if (bus.axi_mosi !== '0) $display("FAIL reset_axi_mosi: got %h expected 0", bus.axi_mosi); else pass_cnt++;
        total_cnt++; if (bus.axis_mosi !== '0) $display("FAIL reset_axis_mosi: got %h expected 0", bus.axis_mosi); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else pass_cnt++;
        total_cnt++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b expected 0", done_o); else pass_cnt++;
        total_cnt++; if (err_o !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_o); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_len1();
        bit ok;
        clear_monitor();
        use_override = 1'b1;
        run_cmd(16'd1, ok);
        repeat (3) @(negedge clk);
        use_override = 1'b0;
        total_cnt++; if (ok !== 1'b1) $display("FAIL len1_timeout: done seen %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (ar_hs_cnt !== 1) $display("FAIL len1_ar_count: got %0d expected 1", ar_hs_cnt); else pass_cnt++;
        total_cnt++; if (arlen_q.size() != 1 || arlen_q[0] !== 8'd0) $display("FAIL len1_arlen: got size %0d first %0d expected 1/0", arlen_q.size(), arlen_q.size() > 0 ? arlen_q[0] : 8'hFF); else pass_cnt++;
        total_cnt++; if (byte_q.size() != 1 || byte_q[0] !== 8'hAA || last_q[0] !== 1'b1) $display("FAIL len1_byte: got %0d bytes first %h expected 1 byte AA with tlast", byte_q.size(), byte_q.size() > 0 ? byte_q[0] : 8'h00); else pass_cnt++;
        total_cnt++; if (done_cnt !== 1) $display("FAIL len1_done_count: got %0d expected 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_len7();
        bit ok;
        clear_monitor();
        run_cmd(16'd7, ok);
        #2;
        total_cnt++; if (busy_o !== 1'b1) $display("FAIL len7_busy_in_done: got %b expected 1", busy_o); else pass_cnt++;
        @(negedge clk);
        #2;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL len7_busy_after_done: got %b expected 0", busy_o); else pass_cnt++;
        repeat (2) @(negedge clk);
        total_cnt++; if (ok !== 1'b1) $display("FAIL len7_timeout: done seen %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (arlen_q.size() != 1 || arlen_q[0] !== 8'd1) $display("FAIL len7_arlen: got size %0d expected one AR with arlen 1", arlen_q.size()); else pass_cnt++;
        total_cnt++; if (byte_q.size() != 7) $display("FAIL len7_byte_count: got %0d expected 7", byte_q.size()); else pass_cnt++;
        total_cnt++; if (pattern_errs(7) != 0) $display("FAIL len7_pattern: got %0d bad bytes expected 0", pattern_errs(7)); else pass_cnt++;
        total_cnt++; if (done_cnt !== 1) $display("FAIL len7_done_count: got %0d expected 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_len70();
        bit ok;
        clear_monitor();
        run_cmd(16'd70, ok);
        repeat (3) @(negedge clk);
        total_cnt++; if (ok !== 1'b1) $display("FAIL len70_timeout: done seen %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (arlen_q.size() != 2 || arlen_q[0] !== 8'd15 || arlen_q[1] !== 8'd1) $display("FAIL len70_arlens: got %0d bursts expected arlen 15 then 1", arlen_q.size()); else pass_cnt++;
        total_cnt++; if (overlap_cnt !== 0) $display("FAIL len70_overlap: got %0d expected 0", overlap_cnt); else pass_cnt++;
        total_cnt++; if (byte_q.size() != 70) $display("FAIL len70_byte_count: got %0d expected 70", byte_q.size()); else pass_cnt++;
        total_cnt++; if (pattern_errs(70) != 0) $display("FAIL len70_pattern: got %0d bad bytes expected 0", pattern_errs(70)); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_monitor();
        tready_low = 30;
        ar_delay   = 3;
        run_cmd(16'd20, ok);
        repeat (3) @(negedge clk);
        tready_low = 0;
        ar_delay   = 0;
        total_cnt++; if (ok !== 1'b1) $display("FAIL bp_timeout: done seen %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (arvalid_seen !== 4) $display("FAIL bp_ar_wait: arvalid cycles %0d expected 4", arvalid_seen); else pass_cnt++;
        total_cnt++; if (ar_stab_err !== 0) $display("FAIL bp_ar_stable: got %0d changes expected 0", ar_stab_err); else pass_cnt++;
        total_cnt++; if (axis_stab_err !== 0) $display("FAIL bp_axis_stable: got %0d changes expected 0", axis_stab_err); else pass_cnt++;
        total_cnt++; if (byte_q.size() != 20 || pattern_errs(20) != 0) $display("FAIL bp_bytes: got %0d bytes %0d bad expected 20/0", byte_q.size(), pattern_errs(20)); else pass_cnt++;
    endtask

    task automatic test_rresp_err();
        bit ok;
        clear_monitor();
        err_beat = 1;
        run_cmd(16'd8, ok);
        #2;
        total_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky_done: got %b expected 1", err_o); else pass_cnt++;
        err_beat = -1;
        repeat (3) @(negedge clk);
        total_cnt++; if (err_o !== 1'b1) $display("FAIL err_sticky_idle: got %b expected 1", err_o); else pass_cnt++;
        total_cnt++; if (byte_q.size() != 8 || pattern_errs(8) != 0) $display("FAIL err_bytes: got %0d bytes %0d bad expected 8/0", byte_q.size(), pattern_errs(8)); else pass_cnt++;
        clear_monitor();
        run_cmd(16'd4, ok);
        repeat (2) @(negedge clk);
        total_cnt++; if (err_o !== 1'b0) $display("FAIL err_clear_on_start: got %b expected 0", err_o); else pass_cnt++;
        total_cnt++; if (byte_q.size() != 4 || pattern_errs(4) != 0) $display("FAIL err_next_bytes: got %0d bytes %0d bad expected 4/0", byte_q.size(), pattern_errs(4)); else pass_cnt++;
    endtask

    task automatic test_len0();
        bit ok;
        clear_monitor();
        run_cmd(16'd0, ok);
        repeat (3) @(negedge clk);
        #2;
        total_cnt++; if (done_cnt !== 1) $display("FAIL len0_done_count: got %0d expected 1", done_cnt); else pass_cnt++;
        total_cnt++; if (arvalid_seen !== 0) $display("FAIL len0_no_arvalid: got %0d cycles expected 0", arvalid_seen); else pass_cnt++;
        total_cnt++; if (byte_q.size() != 0) $display("FAIL len0_no_bytes: got %0d expected 0", byte_q.size()); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL len0_idle: busy %b expected 0", busy_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n = 0;
        clear_monitor();
        @(negedge clk);
        cmd_len_i   = 16'd40;
        cmd_start_i = 1'b1;
        while (byte_q.size() < 5 && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        total_cnt++; if (byte_q.size() < 5) $display("FAIL rstmid_reach_data: got %0d bytes expected >=5", byte_q.size()); else pass_cnt++;
        @(negedge clk);
        rst         = 1'b0;
        cmd_start_i = 1'b0;
        @(negedge clk);
        #2;
        total_cnt++; if (bus.axi_mosi !== '0) $display("FAIL rstmid_axi_mosi: got %h expected 0", bus.axi_mosi); else pass_cnt++;
        total_cnt++; if (bus.axis_mosi !== '0) $display("FAIL rstmid_axis_mosi: got %h expected 0", bus.axis_mosi); else pass_cnt++;
        total_cnt++; if ({busy_o, done_o, err_o} !== 3'b000) $display("FAIL rstmid_status: got %b expected 000", {busy_o, done_o, err_o}); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        clear_monitor();
        run_cmd(16'd4, ok);
        repeat (3) @(negedge clk);
        total_cnt++; if (ok !== 1'b1 || done_cnt !== 1) $display("FAIL rstmid_recover_done: got ok %b count %0d expected 1/1", ok, done_cnt); else pass_cnt++;
        total_cnt++; if (arlen_q.size() != 1 || arlen_q[0] !== 8'd0) $display("FAIL rstmid_recover_arlen: got %0d bursts expected one with arlen 0", arlen_q.size()); else pass_cnt++;
        total_cnt++; if (byte_q.size() != 4 || pattern_errs(4) != 0) $display("FAIL rstmid_recover_bytes: got %0d bytes %0d bad expected 4/0", byte_q.size(), pattern_errs(4)); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_len1();
        test_len7();
        test_len70();
        test_backpressure();
        test_rresp_err();
        test_len0();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
